// File: rtl/scale_sequencer.sv
// scale_sequencer: iterative power-of-two scaler that closes the loop around
// an external combinational x2 / /2 stage. A job captures a signed operand,
// a direction and a step count, then runs one stage step per clock with
// saturation to N bits after every step. The final value is presented with a
// one-cycle done pulse and a sticky overflow flag.

module scale_sequencer #(
  parameter int N  = 4,  // operand/result width, must match the stage
  parameter int CW = 3   // step-count width
) (
  input  logic          clk_i,
  input  logic          reset_i,      // synchronous, active-high
  input  logic          start_i,
  input  logic [N-1:0]  operand_i,
  input  logic          dir_i,        // 0 = divide by 2, 1 = multiply by 2
  input  logic [CW-1:0] count_i,
  output logic [N-1:0]  stage_a_o,
  output logic          stage_sel_o,
  input  logic [N+1:0]  stage_ans_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [N-1:0]  result_o,
  output logic          ovf_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Saturation rails expressed at the stage's N+2-bit width.
  localparam logic signed [N+1:0] SAT_MAX = {3'b000, {(N-1){1'b1}}};
  localparam logic signed [N+1:0] SAT_MIN = {3'b111, {(N-1){1'b0}}};
  localparam logic [CW-1:0]       REM_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]       REM_ZERO = {CW{1'b0}};

  // Clamp an N+2-bit stage result into the signed N-bit range.
  function automatic logic [N-1:0] sat_fn(input logic signed [N+1:0] x);
    if (x > SAT_MAX) begin
      sat_fn = SAT_MAX[N-1:0];
    end else if (x < SAT_MIN) begin
      sat_fn = SAT_MIN[N-1:0];
    end else begin
      sat_fn = x[N-1:0];
    end
  endfunction

  // True when the stage result lies outside the signed N-bit range.
  function automatic logic oor_fn(input logic signed [N+1:0] x);
    oor_fn = (x > SAT_MAX) || (x < SAT_MIN);
  endfunction

  state_t        state_q, state_d;
  logic [N-1:0]  val_q,   val_d;
  logic          dir_q,   dir_d;
  logic [CW-1:0] rem_q,   rem_d;
  logic          ovf_q,   ovf_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;

  logic signed [N+1:0] ans_s;

  assign ans_s = $signed(stage_ans_i);

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          val_d = operand_i;
          dir_d = dir_i;
          rem_d = count_i;
          ovf_d = 1'b0;
          if (count_i != REM_ZERO) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          // Hold: result and ovf keep the previous job's values.
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        // The stage sees val_q/dir_q this cycle; its answer is fed back.
        val_d = sat_fn(ans_s);
        rem_d = rem_q - REM_ONE;
        ovf_d = ovf_q | oor_fn(ans_s);
        if (rem_q == REM_ONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        // start is deliberately not looked at here.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered off the next state so they line up
    // exactly with the state they describe.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and status registers with synchronous reset priority.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      val_q   <= {N{1'b0}};
      dir_q   <= 1'b0;
      rem_q   <= REM_ZERO;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign stage_a_o   = val_q;
  assign stage_sel_o = dir_q;
  assign result_o    = val_q;
  assign ovf_o       = ovf_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

  scale_sequencer_chk u_chk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .busy_i  (busy_q),
    .done_i  (done_q)
  );

endmodule

// Protocol properties of the sequencer's status outputs.
module scale_sequencer_chk (
  input logic clk_i,
  input logic reset_i,
  input logic busy_i,
  input logic done_i
);

  // done is only ever seen while the block reports busy.
  a_done_busy : assert property (@(posedge clk_i) disable iff (reset_i)
    done_i |-> busy_i);

  // done is a single-cycle pulse.
  a_done_pulse : assert property (@(posedge clk_i) disable iff (reset_i)
    done_i |=> !done_i);

endmodule

// File: tb/tb_scale_sequencer.sv
// Self-checking bench for scale_sequencer. It models the external x2 / /2
// stage, keeps a scoreboard of expected job results and checks latency,
// per-step stage operands, saturation, ignored starts and reset abort.

module tb_scale_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] operand;
  logic       dir;
  logic [2:0] count;
  logic [3:0] stage_a;
  logic       stage_sel;
  logic [5:0] stage_ans;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       ovf;

  typedef struct {
    logic [3:0] res;
    logic       ovf;
    int         lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  scale_sequencer #(.N(4), .CW(3)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .operand_i   (operand),
    .dir_i       (dir),
    .count_i     (count),
    .stage_a_o   (stage_a),
    .stage_sel_o (stage_sel),
    .stage_ans_i (stage_ans),
    .busy_o      (busy),
    .done_o      (done),
    .result_o    (result),
    .ovf_o       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the combinational x2 / /2 stage (signed, /2 truncates to zero).
  logic signed [5:0] a_ext;
  always_comb begin
    a_ext = {{2{stage_a[3]}}, stage_a};
    if (stage_sel) stage_ans = a_ext <<< 1;
    else           stage_ans = a_ext / 6'sd2;
  end

  // Run one job from the current negedge; optionally poke start while busy.
  task automatic run_job(input int op, input logic d, input int cnt, input logic poke);
    exp_t e;
    exp_t got;
    int   v;
    logic o;
    int   tr[8];
    int   cyc;
    v = op;
    o = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      tr[i] = v;
      if (d) v = v * 2;
      else   v = v / 2;
      if (v > 7) begin
        v = 7;
        o = 1'b1;
      end else if (v < -8) begin
        v = -8;
        o = 1'b1;
      end
    end
    e.res = 4'(v);
    e.ovf = o;
    e.lat = cnt + 1;
    sb_q.push_back(e);

    start   = 1'b1;
    operand = 4'(op);
    dir     = d;
    count   = 3'(cnt);
    @(negedge clk);
    cyc     = 1;
    start   = poke;
    operand = 4'($urandom);
    dir     = 1'($urandom);
    count   = 3'($urandom);

    checks++;
    if (busy !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL accept_state op=%0d cnt=%0d: busy=%b ovf=%b, need busy=1 ovf=0", op, cnt, busy, ovf);
    end

    while (done !== 1'b1 && cyc < 20) begin
      if (cyc <= cnt) begin
        checks++;
        if (stage_a !== 4'(tr[cyc-1]) || stage_sel !== d) begin
          errors++;
          $display("FAIL stage_step op=%0d step=%0d: a=%0d sel=%b, need a=%0d sel=%b",
                   op, cyc, $signed(stage_a), stage_sel, tr[cyc-1], d);
        end
      end
      @(negedge clk);
      cyc++;
      start   = poke;
      operand = 4'($urandom);
      dir     = 1'($urandom);
      count   = 3'($urandom);
    end

    got = sb_q.pop_front();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout op=%0d cnt=%0d: done=%b after %0d cycles, need 1", op, cnt, done, cyc);
    end
    checks++;
    if (cyc !== got.lat) begin
      errors++;
      $display("FAIL latency op=%0d cnt=%0d: got %0d cycles, need %0d", op, cnt, cyc, got.lat);
    end
    checks++;
    if (result !== got.res || ovf !== got.ovf || busy !== 1'b1) begin
      errors++;
      $display("FAIL result op=%0d dir=%b cnt=%0d: result=%0d ovf=%b busy=%b, need result=%0d ovf=%b busy=1",
               op, d, cnt, $signed(result), ovf, busy, $signed(got.res), got.ovf);
    end
  endtask

  // Power-on reset values, then reset in the middle of a running job.
  task automatic test_reset();
    int bad_done;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 4'd0 || ovf !== 1'b0 ||
        stage_sel !== 1'b0 || stage_a !== 4'd0) begin
      errors++;
      $display("FAIL reset_values: busy=%b done=%b result=%0d ovf=%b sel=%b a=%0d, need all 0",
               busy, done, result, ovf, stage_sel, stage_a);
    end

    start = 1'b1; operand = 4'd3; dir = 1'b1; count = 3'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_busy: busy=%b, need 1", busy);
    end
    bad_done = 0;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done !== 1'b0) bad_done++;
    end
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 4'd0 || ovf !== 1'b0 ||
        stage_sel !== 1'b0 || stage_a !== 4'd0) begin
      errors++;
      $display("FAIL midrun_reset_values: busy=%b done=%b result=%0d ovf=%b sel=%b a=%0d, need all 0",
               busy, done, result, ovf, stage_sel, stage_a);
    end
    repeat (7) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad_done++;
    end
    checks++;
    if (bad_done !== 0) begin
      errors++;
      $display("FAIL abort_no_done: %0d cycles with done/busy high, need 0", bad_done);
    end
  endtask

  // Multiply without and with positive saturation.
  task automatic test_mul_sat();
    run_job(3, 1'b1, 1, 1'b0);
    @(negedge clk); start = 1'b0;
    run_job(3, 1'b1, 2, 1'b0);
    @(negedge clk); start = 1'b0;
  endtask

  // Signed divide truncating toward zero.
  task automatic test_div();
    for (int c = 1; c <= 3; c++) begin
      run_job(-7, 1'b0, c, 1'b0);
      @(negedge clk); start = 1'b0;
    end
    run_job(6, 1'b0, 7, 1'b0);
    @(negedge clk); start = 1'b0;
  endtask

  // Negative saturation that holds at the rail.
  task automatic test_neg_sat();
    run_job(-5, 1'b1, 3, 1'b0);
    @(negedge clk); start = 1'b0;
    run_job(7, 1'b1, 7, 1'b0);
    @(negedge clk); start = 1'b0;
  endtask

  // Zero-step job and starts that must be ignored in RUN and DONE.
  task automatic test_zero_ignored();
    run_job(5, 1'b1, 0, 1'b0);
    @(negedge clk); start = 1'b0;
    run_job(1, 1'b1, 2, 1'b1);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 4'd4) begin
      errors++;
      $display("FAIL ignored_start: busy=%b done=%b result=%0d, need busy=0 done=0 result=4",
               busy, done, $signed(result));
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || result !== 4'd4) begin
      errors++;
      $display("FAIL ignored_hold: busy=%b result=%0d, need busy=0 result=4", busy, $signed(result));
    end
  endtask

  // New start in the first IDLE cycle after done.
  task automatic test_back_to_back();
    run_job(3, 1'b1, 2, 1'b0);
    @(negedge clk);
    checks++;
    if (result !== 4'd7 || ovf !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hold: result=%0d ovf=%b busy=%b, need result=7 ovf=1 busy=0",
               $signed(result), ovf, busy);
    end
    run_job(2, 1'b0, 1, 1'b0);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    operand = 4'd0;
    dir     = 1'b0;
    count   = 3'd0;
    test_reset();
    test_mul_sat();
    test_div();
    test_neg_sat();
    test_zero_ignored();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scale_sequencer.md
# scale_sequencer

Iterative power-of-two scaler that sits directly upstream of the ALU's combinational ×2/÷2 stage and closes the loop around it. It captures a signed operand, a direction and a step count. It then drives the stage one step per clock, feeding each result back as the next operand, and saturates to n bits after every step. The final value is presented with a one-cycle done pulse and a sticky overflow flag.

## Interface
- n, 4, operand/result width in bits (signed two's complement); must match the ×2/÷2 stage's n
- CW, 3, width of the step-count input; max steps = 2^CW-1
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- operand  in  n  signed initial value
- dir  in  1  0 = divide by 2 per step, 1 = multiply by 2 per step (same encoding as the stage's sel)
- count  in  CW  number of steps, unsigned
- stage_a  out  n  operand to the ×2/÷2 stage; equals the internal value register
- stage_sel  out  1  sel to the ×2/÷2 stage; equals the latched dir
- stage_ans  in  n+2  signed result returned by the stage (combinational, same cycle)
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse, high in DONE
- result  out  n  signed final value; equals the internal value register
- ovf  out  1  sticky: at least one step saturated in the current job

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: at the edge, val<=operand, dir_r<=dir, rem<=count, ovf<=0.
  - Next state is RUN if count≠0, else DONE.
- IDLE, start=0: hold all registers. result and ovf keep the last job's values.
- RUN: stage_a=val and stage_sel=dir_r, both combinational from registers. At each edge:
  - val<=sat(stage_ans)
  - rem<=rem-1
  - ovf<=ovf | (stage_ans out of range)
  - if rem==1, next state is DONE.
- DONE: done=1. Next state is IDLE unconditionally.
- sat(x) clamps to [-2^(n-1), 2^(n-1)-1] and sign-extends/truncates the n+2-bit value to n bits.
  - Only multiply steps can saturate.
  - Divide follows the stage's signed /2, which truncates toward zero: -7→-3, -1→0.
- A saturated value stays at the rail on further multiply steps. ovf stays 1.
- start while busy is ignored. There is no queueing. start in the DONE cycle is also ignored.
- Inputs operand/dir/count are don't-care except in the IDLE start cycle.

## Timing
- Reset values: state IDLE, val 0 (result=0, stage_a=0), dir_r 0 (stage_sel=0), rem 0, ovf 0, busy 0, done 0.
- Reset has priority over every other condition in every state. Reset mid-RUN aborts the job: no done pulse, outputs return to reset values on the next cycle.
- Latency: start accepted at edge E0. done is high during the cycle after edge E0+count, so start→done is count+1 cycles (count=0 gives 1 cycle).
- busy is high from the cycle after E0 through the done cycle inclusive. Throughput is one job per count+2 cycles minimum.
- result and ovf are valid from the done cycle and held until the next accepted start.
- No combinational path from start/operand to any output. The only input→output path is stage_ans → val, which is registered.

## Test plan
- Reset: assert reset for 2 cycles mid-RUN (n=4, operand 3, dir 1, count 5).
  - -> busy=0, done never pulses, result=0, ovf=0, stage_sel=0 the cycle after reset.
- Multiply with saturation: operand 3, dir 1, count 1.
  - -> done at start+2, result 6, ovf 0.
  - Then count 2 -> result 7 (12 clamped), ovf 1, done at start+3.
- Signed divide: operand -7, dir 0, count 1/2/3.
  - -> results -3 / -1 / 0, ovf 0.
  - stage_a steps -7,-3,-1 on consecutive RUN cycles.
- Negative saturation: operand -5, dir 1, count 3.
  - -> steps clamp to -8 and hold; result -8, ovf 1.
- Zero count and ignored start: operand 5, count 0.
  - -> done at start+1, result 5.
  - Pulse start with new operand during RUN and DONE -> ignored; result unchanged until the next IDLE start.
- Back-to-back: start re-asserted in the first IDLE cycle after done.
  - -> new job accepted, ovf cleared at acceptance, previous result held until then.
